// File: rtl/mc_ctrl_fsm.sv
// rtl/mc_ctrl_fsm.sv - multicycle MIPS control FSM driving datapath strobes, selects and ExtOp
//
// Purpose: sequences each instruction through FETCH/DECODE/EXEC/MEM/WB and
// decodes Op/Funct into datapath controls. Outputs are a combinational
// decode of the state register (plus live Op/Funct in DECODE and Zero in BRANCH).
//
// Ports:
//   clk, rst             clock (rising edge), asynchronous active-high reset
//   Op, Funct            instruction fields IR[31:26], IR[5:0]
//   Zero                 ALU zero flag, used in BRANCH
//   PCWr, IRWr, RFWr, DMWr  write strobes (PC, IR, register file, data memory)
//   ExtOp                immediate extender mode to the downstream extender
//   ALUOp, NPCOp         ALU operation, next-PC source
//   BSel, GPRSel, WDSel  ALU B source, destination register, RF write data source
//   done, illegal        last-cycle pulse, unsupported-instruction pulse
module mc_ctrl_fsm #(
    parameter int unsigned ILLEGAL_TRAP = 0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] Op,
    input  logic [5:0] Funct,
    input  logic       Zero,
    output logic       PCWr,
    output logic       IRWr,
    output logic       RFWr,
    output logic       DMWr,
    output logic [1:0] ExtOp,
    output logic [2:0] ALUOp,
    output logic [1:0] NPCOp,
    output logic       BSel,
    output logic       GPRSel,
    output logic       WDSel,
    output logic       done,
    output logic       illegal
);

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_ADDIU = 6'b001001;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_LUI   = 6'b001111;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [5:0] FN_ADDU  = 6'b100001;
    localparam logic [5:0] FN_SUBU  = 6'b100011;
    localparam logic [5:0] FN_AND   = 6'b100100;
    localparam logic [5:0] FN_OR    = 6'b100101;
    localparam logic [5:0] FN_SLT   = 6'b101010;

    localparam logic [1:0] EXT_ZERO    = 2'b00;
    localparam logic [1:0] EXT_SIGNED  = 2'b01;
    localparam logic [1:0] EXT_HIGHPOS = 2'b10;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b100;

    localparam logic [1:0] NPC_PC4    = 2'b00;
    localparam logic [1:0] NPC_BRANCH = 2'b01;
    localparam logic [1:0] NPC_JUMP   = 2'b10;

    typedef enum logic [3:0] {
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_MEM_RD,
        S_MEM_WR,
        S_WB_ALU,
        S_WB_MEM,
        S_BRANCH,
        S_JUMP,
        S_HALT
    } state_t;

    typedef enum logic [3:0] {
        I_ADDU,
        I_SUBU,
        I_AND,
        I_OR,
        I_SLT,
        I_ADDIU,
        I_ORI,
        I_LUI,
        I_LW,
        I_SW,
        I_BEQ,
        I_J,
        I_BAD
    } instr_t;

    function automatic instr_t decode_instr(input logic [5:0] op, input logic [5:0] funct);
        instr_t k;
        case (op)
            OP_RTYPE: begin
                case (funct)
                    FN_ADDU: k = I_ADDU;
                    FN_SUBU: k = I_SUBU;
                    FN_AND:  k = I_AND;
                    FN_OR:   k = I_OR;
                    FN_SLT:  k = I_SLT;
                    default: k = I_BAD;
                endcase
            end
            OP_ADDIU: k = I_ADDIU;
            OP_ORI:   k = I_ORI;
            OP_LUI:   k = I_LUI;
            OP_LW:    k = I_LW;
            OP_SW:    k = I_SW;
            OP_BEQ:   k = I_BEQ;
            OP_J:     k = I_J;
            default:  k = I_BAD;
        endcase
        return k;
    endfunction

    function automatic logic [1:0] ext_of(input instr_t k);
        logic [1:0] e;
        case (k)
            I_LUI:                      e = EXT_HIGHPOS;
            I_ADDIU, I_LW, I_SW, I_BEQ: e = EXT_SIGNED;
            default:                    e = EXT_ZERO;
        endcase
        return e;
    endfunction

    // lui uses OR: rs is $zero, so the result is just the extender's shifted immediate.
    function automatic logic [2:0] alu_of(input instr_t k);
        logic [2:0] a;
        case (k)
            I_SUBU, I_BEQ:        a = ALU_SUB;
            I_AND:                a = ALU_AND;
            I_OR, I_ORI, I_LUI:   a = ALU_OR;
            I_SLT:                a = ALU_SLT;
            default:              a = ALU_ADD;
        endcase
        return a;
    endfunction

    function automatic logic is_rtype(input instr_t k);
        return (k == I_ADDU) || (k == I_SUBU) || (k == I_AND) || (k == I_OR) || (k == I_SLT);
    endfunction

    state_t state_q, state_d;
    instr_t instr_q;
    instr_t dec_instr;
    instr_t cur_instr;

    // The instruction class is captured at the end of DECODE so ExtOp and the
    // later-cycle controls stay stable even if Op/Funct move afterwards.
    always_comb begin
        dec_instr = decode_instr(Op, Funct);
        cur_instr = (state_q == S_DECODE) ? dec_instr : instr_q;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_FETCH:  state_d = S_DECODE;
            S_DECODE: begin
                case (dec_instr)
                    I_BEQ:   state_d = S_BRANCH;
                    I_J:     state_d = S_JUMP;
                    I_BAD:   state_d = (ILLEGAL_TRAP != 0) ? S_HALT : S_FETCH;
                    default: state_d = S_EXEC;
                endcase
            end
            S_EXEC: begin
                case (instr_q)
                    I_LW:    state_d = S_MEM_RD;
                    I_SW:    state_d = S_MEM_WR;
                    default: state_d = S_WB_ALU;
                endcase
            end
            S_MEM_RD: state_d = S_WB_MEM;
            S_MEM_WR: state_d = S_FETCH;
            S_WB_ALU: state_d = S_FETCH;
            S_WB_MEM: state_d = S_FETCH;
            S_BRANCH: state_d = S_FETCH;
            S_JUMP:   state_d = S_FETCH;
            S_HALT:   state_d = S_HALT;
            default:  state_d = S_FETCH;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_FETCH;
            instr_q <= I_BAD;
        end else begin
            state_q <= state_d;
            if (state_q == S_DECODE) begin
                instr_q <= dec_instr;
            end
        end
    end

    // Everything is forced low while rst is high so an aborted instruction
    // cannot leak a write during the reset window.
    always_comb begin
        PCWr    = 1'b0;
        IRWr    = 1'b0;
        RFWr    = 1'b0;
        DMWr    = 1'b0;
        ExtOp   = EXT_ZERO;
        ALUOp   = ALU_ADD;
        NPCOp   = NPC_PC4;
        BSel    = 1'b0;
        GPRSel  = 1'b0;
        WDSel   = 1'b0;
        done    = 1'b0;
        illegal = 1'b0;
        if (!rst) begin
            case (state_q)
                S_FETCH: begin
                    IRWr  = 1'b1;
                    PCWr  = 1'b1;
                    NPCOp = NPC_PC4;
                end
                S_DECODE: begin
                    ExtOp   = ext_of(dec_instr);
                    illegal = (dec_instr == I_BAD);
                end
                S_EXEC: begin
                    ExtOp = ext_of(cur_instr);
                    ALUOp = alu_of(cur_instr);
                    BSel  = !is_rtype(cur_instr);
                end
                S_MEM_RD: begin
                    ExtOp = ext_of(cur_instr);
                end
                S_MEM_WR: begin
                    ExtOp = ext_of(cur_instr);
                    DMWr  = 1'b1;
                    done  = 1'b1;
                end
                S_WB_ALU: begin
                    ExtOp  = ext_of(cur_instr);
                    RFWr   = 1'b1;
                    WDSel  = 1'b0;
                    GPRSel = !is_rtype(cur_instr);
                    done   = 1'b1;
                end
                S_WB_MEM: begin
                    ExtOp  = ext_of(cur_instr);
                    RFWr   = 1'b1;
                    WDSel  = 1'b1;
                    GPRSel = 1'b1;
                    done   = 1'b1;
                end
                S_BRANCH: begin
                    ExtOp = ext_of(cur_instr);
                    ALUOp = ALU_SUB;
                    BSel  = 1'b0;
                    NPCOp = NPC_BRANCH;
                    PCWr  = Zero;
                    done  = 1'b1;
                end
                S_JUMP: begin
                    ExtOp = ext_of(cur_instr);
                    NPCOp = NPC_JUMP;
                    PCWr  = 1'b1;
                    done  = 1'b1;
                end
                default: begin
                end
            endcase
        end
    end

endmodule
